// File: rtl/la_capture_core_if.sv
// ============================================================================
// Module   : la_capture_core_if
// Brief    : Control, trigger, status and read-back bus of la_capture_core.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface la_capture_core_if #(
    parameter int DATA_WIDTH = 15,
    parameter int ADDR_WIDTH = 9,
    parameter int TRIG_WIDTH = 2
);
    logic                  sample_en_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [TRIG_WIDTH-1:0] trig_i;
    logic [TRIG_WIDTH-1:0] trig_mask_i;
    logic [1:0]            trig_mode_i;
    logic                  trig_any_i;
    logic [ADDR_WIDTH-1:0] pretrig_i;
    logic                  arm_i;
    logic                  abort_i;
    logic                  busy_o;
    logic                  triggered_o;
    logic                  done_o;
    logic [ADDR_WIDTH-1:0] trig_addr_o;
    logic                  rd_en_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;

    modport master (
        output sample_en_i, data_i, trig_i, trig_mask_i, trig_mode_i, trig_any_i,
               pretrig_i, arm_i, abort_i, rd_en_i, rd_addr_i,
        input  busy_o, triggered_o, done_o, trig_addr_o, rd_data_o, rd_valid_o
    );

    modport slave (
        input  sample_en_i, data_i, trig_i, trig_mask_i, trig_mode_i, trig_any_i,
               pretrig_i, arm_i, abort_i, rd_en_i, rd_addr_i,
        output busy_o, triggered_o, done_o, trig_addr_o, rd_data_o, rd_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/la_capture_core.sv
// ============================================================================
// Module   : la_capture_core
// Brief    : Logic-analyzer capture core: armed masked level/edge trigger,
//            pre-trigger circular buffer and synchronous read-back port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module la_capture_core #(
    parameter int DATA_WIDTH = 15,
    parameter int ADDR_WIDTH = 9,
    parameter int TRIG_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    la_capture_core_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_pretrig;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic [TRIG_WIDTH-1:0] r_mask;
    logic [TRIG_WIDTH-1:0] r_prev;
    logic [1:0]            r_mode;
    logic                  r_any;
    logic                  r_prev_valid;
    logic                  r_busy;
    logic                  r_triggered;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_capturing;
    logic                  w_adv;
    logic [TRIG_WIDTH-1:0] w_hit;
    logic                  w_fire;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    assign w_capturing = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_adv       = w_capturing && bus.sample_en_i && !bus.abort_i;

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < TRIG_WIDTH; k++) begin
            case (r_mode)
                2'b00:   w_hit[k] = bus.trig_i[k];
                2'b01:   w_hit[k] = !bus.trig_i[k];
                2'b10:   w_hit[k] = r_prev_valid && !r_prev[k] && bus.trig_i[k];
                default: w_hit[k] = r_prev_valid && r_prev[k] && !bus.trig_i[k];
            endcase
        end
    end

    // Unmasked channels read as hits in AND mode so they cannot block it.
    assign w_fire = (r_mask != '0) &&
                    (r_any ? |(w_hit & r_mask) : &(w_hit | ~r_mask));

    assign w_rd_addr = (r_trig_addr - r_pretrig) + bus.rd_addr_i;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_mem[r_wr_ptr] <= bus.data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_cnt        <= '0;
            r_pretrig    <= '0;
            r_trig_addr  <= '0;
            r_mask       <= '0;
            r_prev       <= '0;
            r_mode       <= 2'b00;
            r_any        <= 1'b0;
            r_prev_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if ((r_state == S_DONE) && bus.rd_en_i) begin
                r_rd_data  <= r_mem[w_rd_addr];
                r_rd_valid <= 1'b1;
            end

            if (w_adv) begin
                r_wr_ptr     <= r_wr_ptr + c_addr_one;
                r_prev       <= bus.trig_i;
                r_prev_valid <= 1'b1;
            end

            if (bus.abort_i) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_triggered <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (bus.arm_i) begin
                            r_mask       <= bus.trig_mask_i;
                            r_mode       <= bus.trig_mode_i;
                            r_any        <= bus.trig_any_i;
                            r_pretrig    <= bus.pretrig_i;
                            r_triggered  <= 1'b0;
                            r_done       <= 1'b0;
                            r_prev_valid <= 1'b0;
                            r_cnt        <= '0;
                            r_busy       <= 1'b1;
                            r_state      <= (bus.pretrig_i == '0) ? S_WAIT : S_PRE;
                        end
                    end
                    S_PRE: begin
                        if (w_adv) begin
                            r_cnt <= r_cnt + c_addr_one;
                            if ((r_cnt + c_addr_one) == r_pretrig) begin
                                r_state <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (w_adv && w_fire) begin
                            r_trig_addr <= r_wr_ptr;
                            r_triggered <= 1'b1;
                            // DEPTH-1-pretrig is the bitwise inverse of pretrig.
                            if (r_pretrig == '1) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_cnt   <= ~r_pretrig;
                                r_state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (w_adv) begin
                            if (r_cnt == c_addr_one) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt - c_addr_one;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy_o      = r_busy;
    assign bus.triggered_o = r_triggered;
    assign bus.done_o      = r_done;
    assign bus.trig_addr_o = r_trig_addr;
    assign bus.rd_data_o   = r_rd_data;
    assign bus.rd_valid_o  = r_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_la_capture_core.sv
// ============================================================================
// Module   : tb_la_capture_core
// Brief    : Self-checking bench for la_capture_core (directed table + random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_la_capture_core;
    localparam int DW    = 15;
    localparam int AW    = 4;
    localparam int TW    = 2;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    la_capture_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TRIG_WIDTH(TW)) bus();

    la_capture_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TRIG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         pre;
        logic [1:0] mask;
        logic [1:0] mode;
        logic       any;
        int         on0, off0, on1, off1;
        int         en_mode;
        int         exp_trig;
        int         exp_rd0;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int g_wptr   = 0;

    // Reference model: every qualified sample since the last arm.
    logic [DW-1:0] q_d[$];
    logic [TW-1:0] q_t[$];
    logic [1:0]    m_mask, m_mode;
    logic          m_any;
    logic [DW-1:0] rd_vals[DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input int i);
        int cnt  = 0;
        int need = 0;
        bit cur, pv, h;
        for (int k = 0; k < TW; k++) begin
            if (m_mask[k]) begin
                need++;
                cur = q_t[i][k];
                pv  = (i > 0) ? q_t[i-1][k] : 1'b0;
                case (m_mode)
                    2'd0:    h = cur;
                    2'd1:    h = !cur;
                    2'd2:    h = (i > 0) && !pv && cur;
                    default: h = (i > 0) && pv && !cur;
                endcase
                if (h) cnt++;
            end
        end
        return m_any ? (cnt > 0) : (need > 0 && cnt == need);
    endfunction

    task automatic arm(input int pre, input logic [1:0] mask, input logic [1:0] mode, input logic any);
        bus.arm_i       = 1'b1;
        bus.sample_en_i = 1'b0;
        bus.pretrig_i   = AW'(pre);
        bus.trig_mask_i = mask;
        bus.trig_mode_i = mode;
        bus.trig_any_i  = any;
        @(negedge clk);
        bus.arm_i = 1'b0;
        m_mask = mask;
        m_mode = mode;
        m_any  = any;
        q_d.delete();
        q_t.delete();
    endtask

    task automatic read_all(input int first);
        bus.sample_en_i = 1'b1;
        bus.rd_en_i     = 1'b1;
        bus.rd_addr_i   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.data_i = DW'($urandom);
            bus.trig_i = TW'($urandom);
            @(negedge clk);
            chk("rd_valid", bus.rd_valid_o, 1);
            chk("rd_data", bus.rd_data_o, q_d[first+i]);
            rd_vals[i] = bus.rd_data_o;
            if (i < DEPTH-1) bus.rd_addr_i = AW'(i+1);
            else             bus.rd_en_i   = 1'b0;
        end
        @(negedge clk);
        chk("rd_valid_pulse", bus.rd_valid_o, 0);
        bus.sample_en_i = 1'b0;
    endtask

    task automatic capture(input int pre, input logic [1:0] mask, input logic [1:0] mode,
                           input logic any, input int en_mode, input bit ramp,
                           input int on0, input int off0, input int on1, input int off1,
                           input int max_cyc);
        int base, n, t;
        bit done, en;
        logic [DW-1:0] d;
        logic [TW-1:0] tr;
        for (int i = 0; i < DEPTH; i++) rd_vals[i] = '1;
        arm(pre, mask, mode, any);
        base = g_wptr;
        t    = -1;
        done = 1'b0;
        chk("arm_busy", bus.busy_o, 1);
        chk("arm_trig_clr", bus.triggered_o, 0);
        chk("arm_done_clr", bus.done_o, 0);
        for (int c = 0; c < max_cyc && !done; c++) begin
            case (en_mode)
                0:       en = 1'b1;
                1:       en = (c % 2 == 0);
                default: en = ($urandom_range(3) != 0);
            endcase
            n = q_d.size();
            if (en && ramp) begin
                d  = DW'(n);
                tr = {(n >= on1 && n < off1), (n >= on0 && n < off0)};
            end else begin
                d  = DW'($urandom) | (ramp ? 15'h4000 : 15'h0000);
                tr = TW'($urandom);
            end
            bus.sample_en_i = en;
            bus.data_i      = d;
            bus.trig_i      = tr;
            if (en) begin
                q_d.push_back(d);
                q_t.push_back(tr);
            end
            @(negedge clk);
            if (en) begin
                n = q_d.size() - 1;
                if (t < 0 && n >= pre && m_hit(n)) t = n;
                done = (t >= 0) && (n >= t + DEPTH - 1 - pre);
            end
            chk("busy", bus.busy_o, !done);
            chk("triggered", bus.triggered_o, (t >= 0));
            chk("done", bus.done_o, done);
        end
        bus.sample_en_i = 1'b0;
        g_wptr = (base + q_d.size()) % DEPTH;
        chk("capture_complete", done, 1);
        if (t >= 0) chk("trig_addr", bus.trig_addr_o, (base + t) % DEPTH);
        if (done) read_all(t - pre);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{pre:4,  mask:2'b01, mode:2'd2, any:1'b0, on0:20, off0:999, on1:999, off1:999, en_mode:0, exp_trig:20, exp_rd0:16};
        tbl[1] = '{pre:4,  mask:2'b11, mode:2'd0, any:1'b0, on0:5,  off0:999, on1:9,   off1:999, en_mode:0, exp_trig:9,  exp_rd0:5};
        tbl[2] = '{pre:0,  mask:2'b01, mode:2'd0, any:1'b0, on0:0,  off0:999, on1:999, off1:999, en_mode:0, exp_trig:0,  exp_rd0:0};
        tbl[3] = '{pre:0,  mask:2'b01, mode:2'd3, any:1'b0, on0:0,  off0:7,   on1:999, off1:999, en_mode:0, exp_trig:7,  exp_rd0:7};
        tbl[4] = '{pre:15, mask:2'b10, mode:2'd1, any:1'b1, on0:999,off0:999, on1:0,   off1:20,  en_mode:0, exp_trig:20, exp_rd0:5};
        tbl[5] = '{pre:2,  mask:2'b11, mode:2'd2, any:1'b1, on0:13, off0:999, on1:10,  off1:999, en_mode:0, exp_trig:10, exp_rd0:8};
        tbl[6] = '{pre:8,  mask:2'b01, mode:2'd2, any:1'b0, on0:12, off0:999, on1:999, off1:999, en_mode:1, exp_trig:12, exp_rd0:4};

        bus.sample_en_i = 0; bus.data_i = '0; bus.trig_i = '0; bus.trig_mask_i = '0;
        bus.trig_mode_i = '0; bus.trig_any_i = 0; bus.pretrig_i = '0; bus.arm_i = 0;
        bus.abort_i = 0; bus.rd_en_i = 0; bus.rd_addr_i = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_triggered", bus.triggered_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_trig_addr", bus.trig_addr_o, 0);
        chk("rst_rd_data", bus.rd_data_o, 0);
        chk("rst_rd_valid", bus.rd_valid_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            capture(tbl[v].pre, tbl[v].mask, tbl[v].mode, tbl[v].any, tbl[v].en_mode, 1'b1,
                    tbl[v].on0, tbl[v].off0, tbl[v].on1, tbl[v].off1, 200);
            chk("tbl_rd0", rd_vals[0], tbl[v].exp_rd0);
            chk("tbl_rd_trig", rd_vals[tbl[v].pre], tbl[v].exp_trig);
        end

        // Arm and abort together: abort wins.
        bus.arm_i = 1'b1; bus.abort_i = 1'b1; bus.pretrig_i = '0;
        bus.trig_mask_i = 2'b01; bus.trig_mode_i = 2'd0;
        @(negedge clk);
        bus.arm_i = 1'b0; bus.abort_i = 1'b0;
        chk("arm_abort_busy", bus.busy_o, 0);
        @(negedge clk);
        chk("arm_abort_busy2", bus.busy_o, 0);

        // mask=00 never triggers; re-arm while busy ignored; reads blocked.
        arm(3, 2'b00, 2'd0, 1'b1);
        bus.rd_en_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.sample_en_i = 1'b1;
            bus.trig_i      = 2'b11;
            bus.data_i      = DW'($urandom);
            bus.rd_addr_i   = AW'($urandom);
            bus.arm_i       = (c == 10);
            bus.trig_mask_i = 2'b11;
            bus.pretrig_i   = '0;
            @(negedge clk);
            chk("mask0_busy", bus.busy_o, 1);
            chk("mask0_triggered", bus.triggered_o, 0);
            chk("early_rd_valid", bus.rd_valid_o, 0);
        end
        bus.arm_i = 1'b0; bus.rd_en_i = 1'b0;
        g_wptr = (g_wptr + 40) % DEPTH;
        bus.sample_en_i = 1'b0; bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_wait_busy", bus.busy_o, 0);

        // Abort during POST.
        arm(0, 2'b01, 2'd0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            bus.sample_en_i = 1'b1;
            bus.trig_i      = (c == 3) ? 2'b01 : 2'b00;
            bus.data_i      = DW'($urandom);
            @(negedge clk);
            chk("post_triggered", bus.triggered_o, (c >= 3));
        end
        g_wptr = (g_wptr + 7) % DEPTH;
        bus.sample_en_i = 1'b0; bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_post_busy", bus.busy_o, 0);
        chk("abort_post_done", bus.done_o, 0);
        chk("abort_post_trig", bus.triggered_o, 0);
        bus.rd_en_i = 1'b1;
        @(negedge clk);
        bus.rd_en_i = 1'b0;
        chk("idle_rd_valid", bus.rd_valid_o, 0);

        // Asynchronous reset mid-capture.
        arm(2, 2'b01, 2'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            bus.sample_en_i = 1'b1;
            bus.trig_i      = 2'b00;
            @(negedge clk);
        end
        bus.sample_en_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", bus.busy_o, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        g_wptr = 0;
        @(negedge clk);

        for (int r = 0; r < 10; r++) begin
            capture($urandom_range(15), 2'($urandom_range(3, 1)), 2'($urandom_range(3)),
                    1'($urandom_range(1)), 2, 1'b0, 0, 0, 0, 0, 500);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
